array_rw_port_arbiter: RTL
==========================

// Module: array_rw_port_arbiter
// PURPOSE
//  Shares one single-port RW SRAM macro between a read requester and a write requester.
//  - Macro: DEPTH x DATA_W; 1-cycle read latency; rdata valid only in the cycle after a read.
//  - Sits between the pipeline and the array wrapper; owns every macro pin.
//  - Zero-initialises the array after reset.
//  - Buffers one write, forwards it to matching reads, and bounds write starvation.
// PARAMETERS
//  DATA_W      261  entry width (bits)
//  ADDR_W      2    address width
//  DEPTH       4    entries; must equal 2**ADDR_W
//  STARVE_LIM  4    max cycles a buffered write may lose arbitration to reads
// PORTS
//  clock          in   1       rising-edge clock
//  reset_n        in   1       asynchronous, active-low reset
//  init_busy      out  1       high while the zero-init sweep runs
//  rd_req_valid   in   1       read request
//  rd_req_ready   out  1       read accepted when valid & ready (rd_fire)
//  rd_req_addr    in   ADDR_W  read address
//  rd_resp_valid  out  1       read data valid; no backpressure
//  rd_resp_data   out  DATA_W  read data
//  wr_req_valid   in   1       write request
//  wr_req_ready   out  1       write accepted when valid & ready (wr_fire)
//  wr_req_addr    in   ADDR_W  write address
//  wr_req_data    in   DATA_W  write data
//  sram_en        out  1       macro enable
//  sram_wmode     out  1       1 = write, 0 = read
//  sram_addr      out  ADDR_W  macro address
//  sram_wmask     out  1       tied to 1 (whole-entry writes)
//  sram_wdata     out  DATA_W  macro write data
//  sram_rdata     in   DATA_W  macro read data (cycle after a read)
// BEHAVIOUR
//  Reset values
//  - State = INIT, init_cnt = 0, wbuf_valid = 0, starve_cnt = 0.
//  - rd_resp_valid = 0, rd_resp_data = 0, req readies = 0, init_busy = 1.
//  - sram_en/wmode/addr/wdata = 0.
//  FSM
//  - INIT: sram_en = 1, wmode = 1, addr = init_cnt, wdata = 0; init_cnt increments each cycle.
//  - INIT: both readies = 0. When init_cnt == DEPTH-1 -> RUN (DEPTH cycles total).
//  - RUN: terminal state. init_busy = (state == INIT).
//  Read acceptance (RUN)
//  - rd_req_ready = !(wbuf_valid && starve_cnt == STARVE_LIM); independent of valids.
//  - rd_fire drives a macro read of rd_req_addr the same cycle.
//  - rd_resp_valid asserts exactly 1 cycle later.
//  Write buffer (RUN)
//  - Port is granted to the write when wbuf_valid && !rd_fire.
//  - Granted write drives: sram_en = 1, wmode = 1, addr/wdata = wbuf contents; wbuf_valid clears.
//  - wr_req_ready = !wbuf_valid || (wbuf_valid && !rd_fire). Combinational from rd_req_valid by design.
//  - wr_fire loads wbuf at the clock edge; 1 write per cycle sustained with no reads.
//  - starve_cnt: +1 each cycle wbuf_valid && rd_fire; cleared on drain or wr_fire into an empty buffer.
//  - starve_cnt saturates at STARVE_LIM, which blocks reads for 1 cycle and forces the drain.
//  Forwarding
//  - rd_fire with wbuf_valid && addrs equal: bypass_q <= 1, byp_data_q <= wbuf_data.
//  - The macro read is still issued; the response uses byp_data_q.
//  - rd_resp_data = rd_resp_valid ? (bypass_q ? byp_data_q : sram_rdata) : 0.
//  Simultaneous events
//  - rd_fire + wr_fire to the same addr in one cycle: read returns the prior value
//    (older wbuf entry if it matches, else array); read is ordered first.
//  - A write to an addr already held in wbuf is accepted only after the drain; order is preserved.
//  - Idle cycle (no read, no wbuf): sram_en = 0.
//  Reset mid-operation
//  - reset_n low at any time discards wbuf and any in-flight response (rd_resp_valid -> 0).
//  - FSM restarts INIT from addr 0.
// CONFIGURATION
//  ARRAY_ARB_PERF_EN
//  - Defined: adds outputs perf_rd_cnt, perf_wr_cnt, perf_byp_cnt (32-bit each).
//  - Counters count rd_fire, granted array writes (excl. INIT), forwarded reads.
//  - Counters saturate at 2^32-1 and reset to 0.
//  - Undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset release -> init_busy = 1 for exactly 4 cycles; addr 0..3 written with 0.
//     Then read addr 2 -> rd_resp_valid next cycle, data = 0.
//  2. Write addr1 = 0x1_ABCD (no reads) -> sram write next cycle.
//     Read addr1 later -> 0x1_ABCD from the array (bypass_q = 0).
//  3. Write addr3 = 0x55 while reads occupy the port; read addr3 next cycle -> 0x55 via bypass.
//  4. Continuous reads with wbuf full, STARVE_LIM = 4 -> rd_req_ready low in cycle 5 only.
//     The write drains that cycle; reads resume.
//  5. Same-cycle read + write to addr0 (old 0x7, new 0x9) -> response 0x7.
//     A following read returns 0x9.
//  6. reset_n low during INIT cycle 2 and with wbuf full -> all outputs at reset values.
//     INIT reruns from addr 0; the buffered write is never issued.
//     With ARRAY_ARB_PERF_EN: counters read 0 after reset and match fire counts.

Source files
------------

// File: rtl/array_rw_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// array_rw_port_arbiter_if
//   Bundles every handshake and macro signal of the read/write port arbiter.
//   The arbiter connects through the slave modport. The pipeline and SRAM
//   side (or a testbench) connects through the master modport.
//
//   Parameters
//     DATA_W  entry width in bits
//     ADDR_W  address width in bits
//
//   Signals (direction seen from the arbiter)
//     init_busy      out  high while the zero-init sweep runs
//     rd_req_*       in   read request (valid/addr), ready is out
//     rd_resp_*      out  read response (valid/data), no backpressure
//     wr_req_*       in   write request (valid/addr/data), ready is out
//     sram_*         out  macro pins (en/wmode/addr/wmask/wdata)
//     sram_rdata     in   macro read data, valid the cycle after a read
// ----------------------------------------------------------------------------
interface array_rw_port_arbiter_if #(
    parameter int DATA_W = 261,
    parameter int ADDR_W = 2
);
    logic              init_busy;

    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_resp_data;

    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;

    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        output init_busy,
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready,
        output rd_resp_valid, rd_resp_data,
        input  wr_req_valid, wr_req_addr, wr_req_data,
        output wr_req_ready,
        output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
        input  sram_rdata
    );

    modport master (
        input  init_busy,
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready,
        input  rd_resp_valid, rd_resp_data,
        output wr_req_valid, wr_req_addr, wr_req_data,
        input  wr_req_ready,
        input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/array_rw_port_arbiter.sv
// ----------------------------------------------------------------------------
// array_rw_port_arbiter
//   Shares one single-port RW SRAM macro (1-cycle read latency) between a
//   read requester and a write requester. After reset, the arbiter sweeps
//   the whole array with zeros. It then arbitrates with reads first. One
//   write is held in a buffer. A read that matches the buffered address gets
//   the buffered data forwarded to it. A buffered write may lose arbitration
//   to reads for at most STARVE_LIM cycles. After that, reads are blocked for
//   one cycle so the write can drain.
//
//   Ports
//     clock    rising-edge clock
//     reset_n  asynchronous, active-low reset
//     bus      array_rw_port_arbiter_if.slave (requests, response, macro pins)
//     perf_*   32-bit saturating event counters (optional, see below)
//
//   Optional feature macro: ARRAY_ARB_PERF_EN
//     When defined, the module adds the outputs perf_rd_cnt, perf_wr_cnt and
//     perf_byp_cnt. These count accepted reads, granted array writes (the
//     init sweep is not counted) and forwarded reads.
// ----------------------------------------------------------------------------
module array_rw_port_arbiter #(
    parameter int DATA_W     = 261,
    parameter int ADDR_W     = 2,
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    array_rw_port_arbiter_if.slave bus
`ifdef ARRAY_ARB_PERF_EN
    ,
    output logic [31:0]            perf_rd_cnt,
    output logic [31:0]            perf_wr_cnt,
    output logic [31:0]            perf_byp_cnt
`endif
);

    localparam int STARVE_W = $clog2(STARVE_LIM + 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   init_cnt;
    logic                init_busy_q;

    logic                wbuf_valid;
    logic [ADDR_W-1:0]   wbuf_addr;
    logic [DATA_W-1:0]   wbuf_data;
    logic [STARVE_W-1:0] starve_cnt;

    logic                rd_resp_valid_q;
    logic                bypass_q;
    logic [DATA_W-1:0]   byp_data_q;

    logic                run;
    logic                starved;
    logic                rd_fire;
    logic                wr_fire;
    logic                wr_grant;
    logic                fwd_hit;

    logic                sram_en_c;
    logic                sram_wmode_c;
    logic [ADDR_W-1:0]   sram_addr_c;
    logic [DATA_W-1:0]   sram_wdata_c;

    // Reads have priority. The exception is a saturated starvation counter,
    // which holds reads off for one cycle so the buffered write gets the port.
    assign run      = (state == ST_RUN);
    assign starved  = wbuf_valid && (starve_cnt == STARVE_W'(STARVE_LIM));
    assign rd_fire  = bus.rd_req_valid && bus.rd_req_ready;
    assign wr_fire  = bus.wr_req_valid && bus.wr_req_ready;
    assign wr_grant = run && wbuf_valid && !rd_fire;
    assign fwd_hit  = rd_fire && wbuf_valid && (wbuf_addr == bus.rd_req_addr);

    // The buffer can accept a new write when it is empty, or when its current
    // entry drains this cycle. A write to the same address as the buffered
    // entry therefore lands only after that entry has reached the array.
    assign bus.rd_req_ready = run && !starved;
    assign bus.wr_req_ready = run && (!wbuf_valid || !rd_fire);

    assign bus.init_busy     = init_busy_q;
    assign bus.rd_resp_valid = rd_resp_valid_q;
    assign bus.rd_resp_data  = rd_resp_valid_q ? (bypass_q ? byp_data_q : bus.sram_rdata)
                                                : '0;

    // Macro pin mux. While reset_n is held low the state is INIT, so the sweep
    // drive is qualified with reset_n to keep the pins at zero during reset.
    always_comb begin
        sram_en_c    = 1'b0;
        sram_wmode_c = 1'b0;
        sram_addr_c  = '0;
        sram_wdata_c = '0;
        if (state == ST_INIT) begin
            sram_en_c    = reset_n;
            sram_wmode_c = reset_n;
            sram_addr_c  = init_cnt;
        end else if (rd_fire) begin
            sram_en_c    = 1'b1;
            sram_addr_c  = bus.rd_req_addr;
        end else if (wbuf_valid) begin
            sram_en_c    = 1'b1;
            sram_wmode_c = 1'b1;
            sram_addr_c  = wbuf_addr;
            sram_wdata_c = wbuf_data;
        end
    end

    assign bus.sram_en    = sram_en_c;
    assign bus.sram_wmode = sram_wmode_c;
    assign bus.sram_addr  = sram_addr_c;
    assign bus.sram_wmask = 1'b1;
    assign bus.sram_wdata = sram_wdata_c;

    // Init sweep FSM together with the write buffer, starvation counter and
    // response pipeline. The sweep lasts DEPTH cycles and RUN is terminal
    // until the next reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_INIT;
            init_cnt        <= '0;
            init_busy_q     <= 1'b1;
            wbuf_valid      <= 1'b0;
            wbuf_addr       <= '0;
            wbuf_data       <= '0;
            starve_cnt      <= '0;
            rd_resp_valid_q <= 1'b0;
            bypass_q        <= 1'b0;
            byp_data_q      <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state       <= ST_RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase

            rd_resp_valid_q <= rd_fire;
            bypass_q        <= fwd_hit;
            if (fwd_hit) begin
                byp_data_q <= wbuf_data;
            end

            if (wr_fire) begin
                wbuf_valid <= 1'b1;
                wbuf_addr  <= bus.wr_req_addr;
                wbuf_data  <= bus.wr_req_data;
            end else if (wr_grant) begin
                wbuf_valid <= 1'b0;
            end

            if (wr_grant || (wr_fire && !wbuf_valid)) begin
                starve_cnt <= '0;
            end else if (wbuf_valid && rd_fire && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

`ifdef ARRAY_ARB_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_rd_cnt  <= '0;
            perf_wr_cnt  <= '0;
            perf_byp_cnt <= '0;
        end else begin
            if (rd_fire && (perf_rd_cnt != '1)) begin
                perf_rd_cnt <= perf_rd_cnt + 1'b1;
            end
            if (wr_grant && (perf_wr_cnt != '1)) begin
                perf_wr_cnt <= perf_wr_cnt + 1'b1;
            end
            if (fwd_hit && (perf_byp_cnt != '1)) begin
                perf_byp_cnt <= perf_byp_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
